// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle: stall requests, multi-cycle EX handshake and redirect
// in, stall vector, EX completion, flush/redirect and monitoring flags out.
// The slave modport is the controller's view; the master modport is the pipeline's view.
interface pipe_ctrl_if #(
  parameter int CNT_W = 6
);

  // Requests from the pipeline stages
  logic             stallreq_if_i;
  logic             stallreq_id_i;
  logic             ex_multi_start_i;
  logic [CNT_W-1:0] ex_multi_cycles_i;
  logic             flush_req_i;
  logic [31:0]      new_pc_i;

  // Controller responses
  logic [5:0]       stall_o;
  logic             ex_done_o;
  logic             flush_o;
  logic [31:0]      new_pc_o;
  logic             stall_timeout_o;
  logic [31:0]      stall_cycles_o;

  modport master (
    output stallreq_if_i,
    output stallreq_id_i,
    output ex_multi_start_i,
    output ex_multi_cycles_i,
    output flush_req_i,
    output new_pc_i,
    input  stall_o,
    input  ex_done_o,
    input  flush_o,
    input  new_pc_o,
    input  stall_timeout_o,
    input  stall_cycles_o
  );

  modport slave (
    input  stallreq_if_i,
    input  stallreq_id_i,
    input  ex_multi_start_i,
    input  ex_multi_cycles_i,
    input  flush_req_i,
    input  new_pc_i,
    output stall_o,
    output ex_done_o,
    output flush_o,
    output new_pc_o,
    output stall_timeout_o,
    output stall_cycles_o
  );

endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller.
// Arbitrates stall requests from fetch, decode and a multi-cycle EX unit into a
// per-stage stall vector, sequences multi-cycle EX ops with a down-counter,
// forwards redirects as a pipeline flush, and keeps two monitors: a sticky
// fetch-timeout flag and a saturating count of stalled cycles.
// Stall vector bit order: 0=pc, 1=if, 2=id, 3=ex, 4=mem, 5=wb.
module pipe_ctrl #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    MULTI = 1'b1
  } state_t;

  localparam logic [5:0]       STALL_NONE = 6'b000000;
  localparam logic [5:0]       STALL_EX   = 6'b001111;
  localparam logic [5:0]       STALL_ID   = 6'b000111;
  localparam logic [5:0]       STALL_IF   = 6'b000011;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO    = CNT_W'(2);
  // Last IF-stall count value before the timeout flag is allowed to set
  localparam logic [15:0]      TMO_LAST   = 16'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      if_cnt;
  logic             timeout_q;
  logic [31:0]      stall_cycles_q;

  logic [CNT_W-1:0] n_req;
  logic             start_long;
  logic             start_short;
  logic             ex_stall;
  logic             ex_done;
  logic [5:0]       stall_vec;

  // Increment that sticks at all-ones instead of wrapping to zero
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Same saturating increment for the fetch-stall run length
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign n_req = bus.ex_multi_cycles_i;

  // Decode EX start/finish and arbitrate the stall vector by priority
  always_comb begin
    start_long  = 1'b0;
    start_short = 1'b0;
    ex_stall    = 1'b0;
    ex_done     = 1'b0;
    stall_vec   = STALL_NONE;

    // A start that coincides with a flush is dropped; starts in MULTI are ignored
    if (state == IDLE && bus.ex_multi_start_i && !bus.flush_req_i) begin
      start_long  = (n_req >= CNT_TWO);
      start_short = (n_req <= CNT_ONE);
    end

    // The issuing cycle plus every MULTI cycle except the last one stall EX
    ex_stall = start_long || (state == MULTI && cnt > CNT_ONE);

    // Single-cycle ops finish immediately; long ops finish on the cnt==1 cycle
    ex_done  = !bus.flush_req_i &&
               (start_short || (state == MULTI && cnt == CNT_ONE));

    if (bus.flush_req_i) begin
      stall_vec = STALL_NONE;
    end else if (ex_stall) begin
      stall_vec = STALL_EX;
    end else if (bus.stallreq_id_i) begin
      stall_vec = STALL_ID;
    end else if (bus.stallreq_if_i) begin
      stall_vec = STALL_IF;
    end else begin
      stall_vec = STALL_NONE;
    end
  end

  // While reset is held every combinational output is forced to zero
  assign bus.stall_o         = rst ? stall_vec : STALL_NONE;
  assign bus.ex_done_o       = rst & ex_done;
  assign bus.flush_o         = rst & bus.flush_req_i;
  assign bus.new_pc_o        = (rst && bus.flush_req_i) ? bus.new_pc_i : 32'd0;
  assign bus.stall_timeout_o = timeout_q;
  assign bus.stall_cycles_o  = stall_cycles_q;

  // Multi-cycle EX sequencer: load N-1 on a long start, count down to 1, abort on flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (bus.flush_req_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_long) begin
            state <= MULTI;
            cnt   <= n_req - CNT_ONE;
          end
        end
        MULTI: begin
          // cnt==1 is the completion cycle; <= also recovers from an impossible 0
          if (cnt <= CNT_ONE) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt   <= cnt - CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Fetch-stall run length and sticky timeout flag; a flush clears both
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if (bus.flush_req_i) begin
      if_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if (bus.stallreq_if_i) begin
      if_cnt <= sat_inc16(if_cnt);
      if (if_cnt >= TMO_LAST) begin
        timeout_q <= 1'b1;
      end
    end else begin
      if_cnt <= '0;
    end
  end

  // Count every cycle in which any stage is stalled, saturating at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
    end else if (stall_vec != STALL_NONE) begin
      stall_cycles_q <= sat_inc32(stall_cycles_q);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: a directed cycle table, hand-written timeout and
// reset-abort sequences, then randomized traffic against a reference model.
module tb_pipe_ctrl;

  localparam int TMO   = 4;
  localparam int CNT_W = 6;

  logic clk;
  logic rst;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_ctrl #(
    .TIMEOUT(TMO),
    .CNT_W  (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Reference model state: cycles left in the EX op (including its done cycle),
  // current run of consecutive fetch stalls, timeout flag, stalled-cycle total.
  int      m_left;
  int      m_if_run;
  bit      m_tmo;
  longint  m_scyc;

  logic [5:0]  m_stall;
  logic        m_done;
  logic        m_flush;
  logic [31:0] m_newpc;

  logic [5:0]  cap_stall;
  logic        cap_done;
  logic        cap_flush;
  logic [31:0] cap_newpc;

  typedef struct {
    logic        fi;
    logic        di;
    logic        st;
    logic [5:0]  n;
    logic        fl;
    logic [31:0] pc;
    logic [5:0]  e_stall;
    logic        e_done;
    logic        e_flush;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic fi, input logic di, input logic st,
                              input logic [5:0] n, input logic fl, input logic [31:0] pc,
                              input logic [5:0] es, input logic ed);
    vec_t v;
    v.fi = fi; v.di = di; v.st = st; v.n = n; v.fl = fl; v.pc = pc;
    v.e_stall = es; v.e_done = ed; v.e_flush = fl;
    v.e_pc = fl ? pc : 32'd0;
    return v;
  endfunction

  task automatic model_reset();
    m_left   = 0;
    m_if_run = 0;
    m_tmo    = 1'b0;
    m_scyc   = 0;
  endtask

  // Expected combinational outputs for this cycle, from the current model state
  task automatic model_comb(input bit r, input bit fi, input bit di, input bit st,
                            input int n, input bit fl, input logic [31:0] pc);
    bit exs;
    if (!r) begin
      model_reset();
      m_stall = 6'd0; m_done = 1'b0; m_flush = 1'b0; m_newpc = 32'd0;
      return;
    end
    exs     = (m_left > 1) || (m_left == 0 && st && n >= 2 && !fl);
    m_done  = !fl && ((m_left == 1) || (m_left == 0 && st && n <= 1));
    m_flush = fl;
    m_newpc = fl ? pc : 32'd0;
    if (fl)       m_stall = 6'b000000;
    else if (exs) m_stall = 6'b001111;
    else if (di)  m_stall = 6'b000111;
    else if (fi)  m_stall = 6'b000011;
    else          m_stall = 6'b000000;
  endtask

  // Advance the model across a clock edge
  task automatic model_edge(input bit r, input bit fi, input bit st, input int n, input bit fl);
    if (!r) begin
      model_reset();
      return;
    end
    if (m_stall != 6'd0 && m_scyc < 64'hFFFF_FFFF) m_scyc++;
    if (fl)                  m_left = 0;
    else if (m_left > 0)     m_left--;
    else if (st && n >= 2)   m_left = n - 1;
    if (fl) begin
      m_if_run = 0;
      m_tmo    = 1'b0;
    end else if (fi) begin
      m_if_run++;
      if (m_if_run >= TMO) m_tmo = 1'b1;
    end else begin
      m_if_run = 0;
    end
  endtask

  // One clock cycle: drive at the falling edge, check 1ns later, then cross the rising edge
  task automatic step(input bit r, input bit fi, input bit di, input bit st,
                      input logic [5:0] n, input bit fl, input logic [31:0] pc);
    rst                   = r;
    bus.stallreq_if_i     = fi;
    bus.stallreq_id_i     = di;
    bus.ex_multi_start_i  = st;
    bus.ex_multi_cycles_i = n;
    bus.flush_req_i       = fl;
    bus.new_pc_i          = pc;
    #1;
    model_comb(r, fi, di, st, int'(n), fl, pc);
    cap_stall = bus.stall_o;
    cap_done  = bus.ex_done_o;
    cap_flush = bus.flush_o;
    cap_newpc = bus.new_pc_o;
    chk("stall_o",         {26'd0, cap_stall},          {26'd0, m_stall});
    chk("ex_done_o",       {31'd0, cap_done},           {31'd0, m_done});
    chk("flush_o",         {31'd0, cap_flush},          {31'd0, m_flush});
    chk("new_pc_o",        cap_newpc,                   m_newpc);
    chk("stall_timeout_o", {31'd0, bus.stall_timeout_o}, {31'd0, m_tmo});
    chk("stall_cycles_o",  bus.stall_cycles_o,          m_scyc[31:0]);
    @(posedge clk);
    model_edge(r, fi, st, int'(n), fl);
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fi_r;
    n_chk  = 0;
    n_fail = 0;
    model_reset();
    rst                   = 1'b0;
    bus.stallreq_if_i     = 1'b0;
    bus.stallreq_id_i     = 1'b0;
    bus.ex_multi_start_i  = 1'b0;
    bus.ex_multi_cycles_i = '0;
    bus.flush_req_i       = 1'b0;
    bus.new_pc_i          = '0;

    // Directed cycle table, one row per clock, starting from reset state
    tbl[0]  = mk(0, 0, 1, 6'd5, 0, 32'h0,        6'b001111, 0);
    tbl[1]  = mk(0, 0, 0, 6'd0, 0, 32'h0,        6'b001111, 0);
    tbl[2]  = mk(0, 0, 0, 6'd0, 0, 32'h0,        6'b001111, 0);
    tbl[3]  = mk(0, 1, 0, 6'd0, 0, 32'h0,        6'b001111, 0);
    tbl[4]  = mk(0, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 1);
    tbl[5]  = mk(0, 0, 1, 6'd1, 0, 32'h0,        6'b000000, 1);
    tbl[6]  = mk(1, 1, 0, 6'd0, 0, 32'h0,        6'b000111, 0);
    tbl[7]  = mk(1, 0, 0, 6'd0, 0, 32'h0,        6'b000011, 0);
    tbl[8]  = mk(0, 0, 1, 6'd8, 0, 32'h0,        6'b001111, 0);
    tbl[9]  = mk(0, 0, 0, 6'd0, 0, 32'h0,        6'b001111, 0);
    tbl[10] = mk(0, 0, 0, 6'd0, 1, 32'hBFC00380, 6'b000000, 0);
    tbl[11] = mk(0, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0);
    tbl[12] = mk(0, 0, 1, 6'd2, 1, 32'h00001234, 6'b000000, 0);
    tbl[13] = mk(0, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0);
    tbl[14] = mk(0, 0, 1, 6'd3, 0, 32'h0,        6'b001111, 0);
    tbl[15] = mk(0, 0, 1, 6'd5, 0, 32'h0,        6'b001111, 0);
    tbl[16] = mk(0, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 1);
    tbl[17] = mk(0, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0);
    tbl[18] = mk(0, 0, 1, 6'd2, 0, 32'h0,        6'b001111, 0);
    tbl[19] = mk(0, 0, 0, 6'd0, 1, 32'hDEADBEEF, 6'b000000, 0);
    tbl[20] = mk(0, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0);
    tbl[21] = mk(0, 0, 1, 6'd0, 0, 32'h0,        6'b000000, 1);

    // Reset held with every input active: outputs must all read zero
    @(negedge clk);
    step(1'b0, 1'b1, 1'b1, 1'b1, 6'd5, 1'b1, 32'hFFFF_FFFF);
    step(1'b0, 1'b0, 0, 0, 6'd0, 1'b0, 32'd0);

    for (int i = 0; i < 22; i++) begin
      step(1'b1, tbl[i].fi, tbl[i].di, tbl[i].st, tbl[i].n, tbl[i].fl, tbl[i].pc);
      chk($sformatf("tbl%0d_stall", i),  {26'd0, cap_stall}, {26'd0, tbl[i].e_stall});
      chk($sformatf("tbl%0d_done", i),   {31'd0, cap_done},  {31'd0, tbl[i].e_done});
      chk($sformatf("tbl%0d_flush", i),  {31'd0, cap_flush}, {31'd0, tbl[i].e_flush});
      chk($sformatf("tbl%0d_newpc", i),  cap_newpc,          tbl[i].e_pc);
    end
    chk("tbl_stall_cycles_total", bus.stall_cycles_o, 32'd11);

    // Fetch timeout: four consecutive IF stalls set the flag, only a flush clears it
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 32'd0);
      chk($sformatf("tmo_after_edge%0d", i + 1), {31'd0, bus.stall_timeout_o},
          (i == 3) ? 32'd1 : 32'd0);
    end
    repeat (3) idle_step();
    chk("tmo_sticky", {31'd0, bus.stall_timeout_o}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 32'h8000_0000);
    chk("tmo_cleared_by_flush", {31'd0, bus.stall_timeout_o}, 32'd0);

    // Reset during a long op: immediate zeros, no done pulse, clean restart
    step(1'b1, 1'b0, 1'b0, 1'b1, 6'd10, 1'b0, 32'd0);
    idle_step();
    idle_step();
    step(1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 32'd0);
    chk("rst_mid_stall",  {26'd0, cap_stall}, 32'd0);
    chk("rst_mid_done",   {31'd0, cap_done},  32'd0);
    chk("rst_mid_cycles", bus.stall_cycles_o, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 6'd2, 1'b0, 32'd0);
    chk("restart_n2_stall", {26'd0, cap_stall}, 32'h0F);
    idle_step();
    chk("restart_n2_done",  {31'd0, cap_done},  32'd1);
    chk("restart_n2_nostall", {26'd0, cap_stall}, 32'd0);
    chk("restart_n2_cycles", bus.stall_cycles_o, 32'd1);

    // Randomized traffic against the model
    fi_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      bit r, di, st, fl;
      logic [5:0] n;
      if ($urandom_range(3) == 0) fi_r = ~fi_r;
      r  = ($urandom_range(99) != 0);
      di = ($urandom_range(4) == 0);
      st = ($urandom_range(3) == 0);
      fl = ($urandom_range(19) == 0);
      n  = 6'($urandom_range(12));
      step(r, fi_r, di, st, n, fl, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, 256, consecutive IF-stall cycles (2..65535) before stall_timeout_o sets.
REQ-002 SHALL have parameter CNT_W, 6, width of the multi-cycle count.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 stallreq_if_i  input  1  fetch waiting on the instruction bus.
REQ-007 stallreq_id_i  input  1  decode load-use hazard.
REQ-008 ex_multi_start_i  input  1  EX begins a multi-cycle op this cycle.
REQ-009 ex_multi_cycles_i  input  CNT_W  total EX cycles of that op (N).
REQ-010 flush_req_i  input  1  exception/redirect request.
REQ-011 new_pc_i  input  32  redirect target.
REQ-012 stall_o  output  6  stall vector; bits 0..5 = pc, if, id, ex, mem, wb.
REQ-013 ex_done_o  output  1  final cycle of the EX op; result valid.
REQ-014 flush_o  output  1  flush all pipeline registers this cycle.
REQ-015 new_pc_o  output  32  redirect target, valid when flush_o=1.
REQ-016 stall_timeout_o  output  1  sticky fetch-timeout flag.
REQ-017 stall_cycles_o  output  32  saturating count of cycles with stall_o!=0.

Function
REQ-018 SHALL implement states IDLE and MULTI, plus a down-counter cnt of width CNT_W.
REQ-019 In IDLE, ex_multi_start_i=1 with N>=2 SHALL load cnt<=N-1 and move to MULTI.
REQ-020 In IDLE, ex_multi_start_i=1 with N<=1 SHALL assert ex_done_o in the same cycle, cause no stall and cause no state change.
REQ-021 In MULTI, cnt SHALL decrement each cycle.
REQ-022 In MULTI, the cnt==1 cycle SHALL assert ex_done_o and return to IDLE on the next edge.
REQ-023 The EX stall condition SHALL be: (IDLE and start and N>=2) or (MULTI and cnt>1); total stalled cycles = N-1.
REQ-024 ex_multi_start_i SHALL be ignored while in MULTI.
REQ-025 stall_o SHALL be combinational, evaluated in this priority order:
- flush_req_i -> 000000
- EX stall condition -> 001111
- stallreq_id_i -> 000111
- stallreq_if_i -> 000011
- otherwise -> 000000
REQ-026 flush_o SHALL equal flush_req_i combinationally.
REQ-027 new_pc_o SHALL equal new_pc_i when flush_req_i=1, else 0.
REQ-028 flush_req_i in MULTI SHALL abort the op: next state IDLE, cnt<=0, ex_done_o=0 that cycle.
REQ-029 flush_req_i together with ex_multi_start_i SHALL ignore the start.
REQ-030 An IF-stall counter SHALL increment each cycle stallreq_if_i=1 and SHALL clear otherwise or on flush.
REQ-031 When the IF-stall counter reaches TIMEOUT-1 with stallreq_if_i still 1, stall_timeout_o SHALL set on the next edge.
REQ-032 stall_timeout_o SHALL clear only on flush_req_i or reset.
REQ-033 stall_cycles_o SHALL increment on each edge where stall_o!=0 and SHALL saturate at 32'hFFFFFFFF without wrapping.
REQ-034 ex_done_o SHALL not assert while flush_req_i=1.

Reset
REQ-035 rst=0 SHALL asynchronously force state IDLE, cnt=0, IF-stall counter=0, stall_timeout_o=0, stall_cycles_o=0.
REQ-036 During reset, the combinational outputs SHALL be stall_o=000000, ex_done_o=0, flush_o=0, new_pc_o=0, regardless of inputs.
REQ-037 Reset asserted mid-MULTI SHALL abandon the op with no ex_done_o pulse.

Verification
REQ-038 Scenario: start, N=5 at cycle T -> stall_o=001111 in T..T+3; ex_done_o=1 in T+4 only; stall_cycles_o=4.
REQ-039 Scenario: start with N=1 -> ex_done_o=1 in the same cycle; stall_o=000000; state stays IDLE.
REQ-040 Scenario: N=8 start, flush_req_i=1 at T+2 with new_pc_i=32'hBFC00380 -> flush_o=1, new_pc_o=32'hBFC00380, stall_o=000000 at T+2; IDLE at T+3; no ex_done_o.
REQ-041 Scenario: stallreq_id_i=1 and stallreq_if_i=1 together -> stall_o=000111.
REQ-042 Scenario: stallreq_id_i=1 during MULTI -> stall_o=001111.
REQ-043 Scenario: TIMEOUT=4, stallreq_if_i held 4 cycles -> stall_timeout_o=1 after the 4th edge; a later flush clears it.
REQ-044 Scenario: rst=0 asserted mid-MULTI (N=10, cycle 3) -> all outputs zero immediately; after release, a new start with N=2 gives a 1-cycle stall.
